// File: rtl/mammal_pkg.sv
// Shared definitions for the mammal_vcpu core.
// Contents: opcode encoding, FSM state encoding (5-bit), ALU operation codes
// and the interrupt priority encoder used to pick the serviced line.
package mammal_pkg;

  typedef enum logic [3:0] {
    OP_LDI  = 4'h0,
    OP_LD   = 4'h1,
    OP_ST   = 4'h2,
    OP_NOP3 = 4'h3,
    OP_JZ   = 4'h4,
    OP_JMP  = 4'h5,
    OP_NOP6 = 4'h6,
    OP_ALU  = 4'h7,
    OP_PUSH = 4'h8,
    OP_POP  = 4'h9,
    OP_CALL = 4'hA,
    OP_RET  = 4'hB,
    OP_STI  = 4'hC,
    OP_CLI  = 4'hD,
    OP_IRET = 4'hE,
    OP_NOPF = 4'hF
  } opcode_e;

  // State register encoding; kept as plain constants so older tooling and
  // waveform scripts see stable numeric values.
  typedef logic [4:0] state_e;

  localparam state_e S_FETCH = 5'd0;
  localparam state_e S_LDI   = 5'd1;
  localparam state_e S_LD    = 5'd2;
  localparam state_e S_ST    = 5'd3;
  localparam state_e S_JMP   = 5'd4;
  localparam state_e S_ALU   = 5'd5;
  localparam state_e S_PUSH  = 5'd6;
  localparam state_e S_POP1  = 5'd7;
  localparam state_e S_POP2  = 5'd8;
  localparam state_e S_CALL  = 5'd9;
  localparam state_e S_RET1  = 5'd10;
  localparam state_e S_RET2  = 5'd11;
  localparam state_e S_STI   = 5'd12;
  localparam state_e S_CLI   = 5'd13;
  localparam state_e S_IRET1 = 5'd14;
  localparam state_e S_IRET2 = 5'd15;
  localparam state_e S_IRET3 = 5'd16;
  localparam state_e S_INT1  = 5'd17;
  localparam state_e S_INT2  = 5'd18;
  localparam state_e S_INT3  = 5'd19;

  // ALU operation field ir[11:9]
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SHL = 3'd5;
  localparam logic [2:0] ALU_UN  = 3'd7;

  // Unary sub-operation field ir[8:6] (only meaningful with ALU_UN)
  localparam logic [2:0] UN_NOT = 3'd0;
  localparam logic [2:0] UN_MOV = 3'd1;
  localparam logic [2:0] UN_INC = 3'd2;
  localparam logic [2:0] UN_DEC = 3'd3;

  // Lowest set index wins; requests are zero-extended to 8 lines by the caller.
  function automatic logic [2:0] prio_enc(input logic [7:0] req);
    logic [2:0] id;
    id = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) begin
        id = 3'(i);
      end else begin
        id = id;
      end
    end
    return id;
  endfunction

endpackage

// File: rtl/mammal_alu.sv
// Combinational ALU for mammal_vcpu.
// Ports: op (ir[11:9]), un (ir[8:6] unary select), a = R[rt], b = R[rs],
//        result (DW bits, modulo 2**DW), zero (result == 0).
module mammal_alu
  import mammal_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [2:0]    op,
  input  logic [2:0]    un,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result,
  output logic          zero
);

  localparam logic [DW-1:0] DW_ONE   = DW'(1'b1);
  localparam logic [DW-1:0] DW_WIDTH = DW'(DW);

  logic [DW-1:0] sh_s;
  logic [DW-1:0] res_s;

  // Operation select; shift distance is taken modulo the data width.
  always_comb begin
    sh_s = b % DW_WIDTH;
    case (op)
      ALU_ADD: res_s = a + b;
      ALU_SUB: res_s = a - b;
      ALU_AND: res_s = a & b;
      ALU_OR:  res_s = a | b;
      ALU_XOR: res_s = a ^ b;
      ALU_SHL: res_s = a << sh_s;
      ALU_UN: begin
        case (un)
          UN_NOT:  res_s = (b == {DW{1'b0}}) ? DW_ONE : {DW{1'b0}};
          UN_MOV:  res_s = b;
          UN_INC:  res_s = b + DW_ONE;
          UN_DEC:  res_s = b - DW_ONE;
          default: res_s = {DW{1'b0}};
        endcase
      end
      default: res_s = {DW{1'b0}};
    endcase
  end

  assign result = res_s;
  assign zero   = (res_s == {DW{1'b0}});

endmodule

// File: rtl/mammal_vcpu.sv
// mammal_vcpu: parametrised multicycle CPU with vectored, prioritised,
// nestable interrupts.
// Ports: clk, rst_n (async active-low), data_in (combinational memory read),
//        data_out/address/memwt (single-cycle memory write), irq (level
//        requests, lower index = higher priority), intack (one-hot ack
//        pulsed in INT2), int_busy (high during INT1..INT3).
module mammal_vcpu
  import mammal_pkg::*;
#(
  parameter int DW       = 16,
  parameter int AW       = 12,
  parameter int NIRQ     = 4,
  parameter int VEC_BASE = 32'h0DC,
  parameter int RESET_PC = 32'd0,
  parameter int SP_RESET = 32'hFFF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [DW-1:0]   data_in,
  output logic [DW-1:0]   data_out,
  output logic [AW-1:0]   address,
  output logic            memwt,
  input  logic [NIRQ-1:0] irq,
  output logic [NIRQ-1:0] intack,
  output logic            int_busy
);

  localparam logic [AW-1:0] VEC_BASE_C = AW'(VEC_BASE);
  localparam logic [AW-1:0] RESET_PC_C = AW'(RESET_PC);
  localparam logic [DW-1:0] SP_RESET_C = DW'(SP_RESET);
  localparam logic [AW-1:0] AW_ONE     = AW'(1'b1);
  localparam logic [DW-1:0] DW_ONE     = DW'(1'b1);

  state_e        state_r, state_nxt_s;
  logic [AW-1:0] pc_r, pc_nxt_s;
  logic [11:0]   ir_r, ir_nxt_s;
  logic [DW-1:0] regs_r [8];
  logic          z_r, z_nxt_s;
  logic          ie_r, ie_nxt_s;
  logic          ie_tmp_r, ie_tmp_nxt_s;
  logic [2:0]    id_r, id_nxt_s;

  logic          rf_we_s;
  logic [DW-1:0] rf_wd_s;
  logic [DW-1:0] r7_nxt_s;
  logic          chk_s;
  logic          int_go_s;

  logic [2:0]    rd_s, rs_s, rt_s;
  logic [DW-1:0] rs_val_s, rt_val_s;
  logic [AW-1:0] sp_s, ir_off_s;
  logic [DW-1:0] alu_res_s;
  logic          alu_zero_s;
  opcode_e       op_s;

  assign rd_s     = ir_r[2:0];
  assign rs_s     = ir_r[5:3];
  assign rt_s     = ir_r[8:6];
  assign rs_val_s = regs_r[rs_s];
  assign rt_val_s = regs_r[rt_s];
  assign sp_s     = regs_r[7][AW-1:0];
  assign ir_off_s = AW'(ir_r);
  assign op_s     = opcode_e'(data_in[15:12]);
  // IE is read before this cycle's update, giving STI its one-instruction shadow.
  assign int_go_s = ie_r & (|irq);

  mammal_alu #(.DW(DW)) u_alu (
    .op     (ir_r[11:9]),
    .un     (ir_r[8:6]),
    .a      (rt_val_s),
    .b      (rs_val_s),
    .result (alu_res_s),
    .zero   (alu_zero_s)
  );

  // Next-state, datapath control and memory interface decode.
  always_comb begin
    state_nxt_s  = S_FETCH;
    pc_nxt_s     = pc_r;
    ir_nxt_s     = ir_r;
    z_nxt_s      = z_r;
    ie_nxt_s     = ie_r;
    ie_tmp_nxt_s = ie_tmp_r;
    id_nxt_s     = id_r;
    rf_we_s      = 1'b0;
    rf_wd_s      = {DW{1'b0}};
    r7_nxt_s     = regs_r[7];
    chk_s        = 1'b0;
    address      = pc_r;
    data_out     = {DW{1'b0}};
    memwt        = 1'b0;
    intack       = {NIRQ{1'b0}};
    int_busy     = 1'b0;
    case (state_r)
      S_FETCH: begin
        ir_nxt_s = data_in[11:0];
        pc_nxt_s = pc_r + AW_ONE;
        case (op_s)
          OP_LDI:  state_nxt_s = S_LDI;
          OP_LD:   state_nxt_s = S_LD;
          OP_ST:   state_nxt_s = S_ST;
          OP_JZ:   state_nxt_s = z_r ? S_JMP : S_FETCH;
          OP_JMP:  state_nxt_s = S_JMP;
          OP_ALU:  state_nxt_s = S_ALU;
          OP_PUSH: state_nxt_s = S_PUSH;
          OP_POP:  state_nxt_s = S_POP1;
          OP_CALL: state_nxt_s = S_CALL;
          OP_RET:  state_nxt_s = S_RET1;
          OP_STI:  state_nxt_s = S_STI;
          OP_CLI:  state_nxt_s = S_CLI;
          OP_IRET: state_nxt_s = S_IRET1;
          default: state_nxt_s = S_FETCH;
        endcase
      end
      S_LDI: begin
        rf_we_s  = 1'b1;
        rf_wd_s  = data_in;
        pc_nxt_s = pc_r + AW_ONE;
        chk_s    = 1'b1;
      end
      S_LD: begin
        address = rs_val_s[AW-1:0];
        rf_we_s = 1'b1;
        rf_wd_s = data_in;
        chk_s   = 1'b1;
      end
      S_ST: begin
        address  = rs_val_s[AW-1:0];
        data_out = rt_val_s;
        memwt    = 1'b1;
        chk_s    = 1'b1;
      end
      S_JMP: begin
        pc_nxt_s = pc_r + ir_off_s;
        chk_s    = 1'b1;
      end
      S_ALU: begin
        rf_we_s = 1'b1;
        rf_wd_s = alu_res_s;
        z_nxt_s = alu_zero_s;
        chk_s   = 1'b1;
      end
      S_PUSH: begin
        address  = sp_s;
        data_out = rt_val_s;
        memwt    = 1'b1;
        r7_nxt_s = regs_r[7] - DW_ONE;
        chk_s    = 1'b1;
      end
      S_POP1: begin
        r7_nxt_s    = regs_r[7] + DW_ONE;
        state_nxt_s = S_POP2;
      end
      S_POP2: begin
        address = sp_s;
        rf_we_s = 1'b1;
        rf_wd_s = data_in;
        chk_s   = 1'b1;
      end
      S_CALL: begin
        address  = sp_s;
        data_out = DW'(pc_r);
        memwt    = 1'b1;
        r7_nxt_s = regs_r[7] - DW_ONE;
        pc_nxt_s = pc_r + ir_off_s;
        chk_s    = 1'b1;
      end
      S_RET1: begin
        r7_nxt_s    = regs_r[7] + DW_ONE;
        state_nxt_s = S_RET2;
      end
      S_RET2: begin
        address  = sp_s;
        pc_nxt_s = data_in[AW-1:0];
        chk_s    = 1'b1;
      end
      S_STI: begin
        ie_nxt_s = 1'b1;
        chk_s    = 1'b1;
      end
      S_CLI: begin
        // No interrupt check here: a CLI boundary is never interrupted.
        ie_nxt_s = 1'b0;
      end
      S_IRET1: begin
        address     = sp_s;
        r7_nxt_s    = regs_r[7] + DW_ONE;
        state_nxt_s = S_IRET2;
      end
      S_IRET2: begin
        address      = sp_s;
        z_nxt_s      = data_in[0];
        ie_tmp_nxt_s = data_in[1];
        r7_nxt_s     = regs_r[7] + DW_ONE;
        state_nxt_s  = S_IRET3;
      end
      S_IRET3: begin
        address  = sp_s;
        pc_nxt_s = data_in[AW-1:0];
        ie_nxt_s = ie_tmp_r;
        chk_s    = 1'b1;
      end
      S_INT1: begin
        address     = sp_s;
        data_out    = DW'(pc_r);
        memwt       = 1'b1;
        r7_nxt_s    = regs_r[7] - DW_ONE;
        ie_nxt_s    = 1'b0;
        int_busy    = 1'b1;
        state_nxt_s = S_INT2;
      end
      S_INT2: begin
        // Status word: bit1 = IE at entry (always 1 on this path), bit0 = Z.
        address     = sp_s;
        data_out    = DW'({1'b1, z_r});
        memwt       = 1'b1;
        r7_nxt_s    = regs_r[7] - DW_ONE;
        intack      = NIRQ'(1'b1) << id_r;
        int_busy    = 1'b1;
        state_nxt_s = S_INT3;
      end
      S_INT3: begin
        address     = VEC_BASE_C + AW'(id_r);
        pc_nxt_s    = data_in[AW-1:0];
        int_busy    = 1'b1;
        state_nxt_s = S_FETCH;
      end
      default: begin
        state_nxt_s = S_FETCH;
      end
    endcase
    // Instruction boundary: the serviced line is frozen here.
    if (chk_s && int_go_s) begin
      state_nxt_s = S_INT1;
      id_nxt_s    = prio_enc(8'(irq));
    end else begin
      id_nxt_s = id_nxt_s;
    end
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= S_FETCH;
      pc_r     <= RESET_PC_C;
      ir_r     <= 12'h000;
      z_r      <= 1'b0;
      ie_r     <= 1'b0;
      ie_tmp_r <= 1'b0;
      id_r     <= 3'd0;
    end else begin
      state_r  <= state_nxt_s;
      pc_r     <= pc_nxt_s;
      ir_r     <= ir_nxt_s;
      z_r      <= z_nxt_s;
      ie_r     <= ie_nxt_s;
      ie_tmp_r <= ie_tmp_nxt_s;
      id_r     <= id_nxt_s;
    end
  end

  // Register file; a load into R7 takes precedence over the stack adjust.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 7; i++) begin
        regs_r[i] <= {DW{1'b0}};
      end
      regs_r[7] <= SP_RESET_C;
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (rf_we_s && (rd_s == 3'(i))) begin
          regs_r[i] <= rf_wd_s;
        end else begin
          regs_r[i] <= regs_r[i];
        end
      end
      regs_r[7] <= (rf_we_s && (rd_s == 3'd7)) ? rf_wd_s : r7_nxt_s;
    end
  end

endmodule
